// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request at a time, results buffered
// in a small show-ahead FIFO toward decode; redirect flushes everything in flight.
module fetch_unit #(
    parameter int DEPTH   = 2,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc_in,
    input  logic               redirect,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               pc_advance,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [31:0]        addr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic [INSTR_W-1:0] last_instr_reg;
    logic [31:0]        last_pc_reg;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [31:0]        pc_mem    [DEPTH];

    logic launch;
    logic push;
    logic pop;

    // Space is judged on the count before this cycle's pop, so a full FIFO always waits one cycle.
    assign launch = (state_reg == S_IDLE) && !redirect && (count_reg < DEPTH_CNT);
    assign push   = pc_advance;
    assign pop    = id_valid && id_ready && !redirect;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (launch) state_next = S_WAIT;
            S_WAIT: begin
                if (imem_ack) begin
                    state_next = S_IDLE;
                end else if (redirect) begin
                    state_next = S_DRAIN;
                end
            end
            // A request once issued is never withdrawn; its stale response is swallowed here.
            S_DRAIN: if (imem_ack) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        imem_req   = (state_reg == S_WAIT) || (state_reg == S_DRAIN);
        imem_addr  = addr_reg;
        pc_advance = (state_reg == S_WAIT) && imem_ack && !redirect;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg <= '0;
        end else if (launch) begin
            addr_reg <= pc_in;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!reset && push && (wr_ptr_reg == PTR_W'(gi))) begin
                    instr_mem[gi] <= imem_rdata;
                    pc_mem[gi]    <= addr_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Decode sees the last consumed entry again whenever the FIFO runs empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_instr_reg <= '0;
            last_pc_reg    <= '0;
        end else if (pop) begin
            last_instr_reg <= instr_mem[rd_ptr_reg];
            last_pc_reg    <= pc_mem[rd_ptr_reg];
        end
    end

    always_comb begin
        id_valid = (count_reg != '0);
        id_instr = last_instr_reg;
        id_pc    = last_pc_reg;
        if (id_valid) begin
            id_instr = instr_mem[rd_ptr_reg];
            id_pc    = pc_mem[rd_ptr_reg];
        end
    end

endmodule
